// File: rtl/dispense_actuator_pkg.sv
// Shared definitions for the pill-dispense actuator.
//   state_t        : FSM state encoding (3 bits)
//   comp_t         : compartment codes driven on the compartment output
//   pick_compartment : lowest-numbered pending dose (morning first)
//   comp_mask      : one-hot pending-bit mask for a compartment code
package dispense_actuator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ROTATE    = 3'd1,
    ST_WAIT_DROP = 3'd2,
    ST_ALERT     = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    COMP_NONE      = 2'd0,
    COMP_MORNING   = 2'd1,
    COMP_AFTERNOON = 2'd2,
    COMP_EVENING   = 2'd3
  } comp_t;

  // pending[0]=morning, [1]=afternoon, [2]=evening
  function automatic comp_t pick_compartment(input logic [2:0] pending);
    comp_t c;
    c = COMP_NONE;
    if (pending[0])      c = COMP_MORNING;
    else if (pending[1]) c = COMP_AFTERNOON;
    else if (pending[2]) c = COMP_EVENING;
    return c;
  endfunction

  function automatic logic [2:0] comp_mask(input comp_t c);
    logic [2:0] m;
    m = 3'b000;
    case (c)
      COMP_MORNING:   m = 3'b001;
      COMP_AFTERNOON: m = 3'b010;
      COMP_EVENING:   m = 3'b100;
      default:        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dispense_actuator_ms_tick.sv
// ms_tick_gen: free-running prescaler producing a one-cycle tick every
// CLKS_PER_MS clock cycles.
//   CLOCK_50 : clock
//   reset    : asynchronous, active-high
//   tick     : one-cycle pulse, period CLKS_PER_MS cycles
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == LAST) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/dispense_actuator.sv
// dispense_actuator: queues morning/afternoon/evening dose requests, rotates
// the carousel to the selected compartment, waits for the pill-drop sensor
// (retrying up to MAX_RETRY times), then alerts the patient until they
// acknowledge or the alert window expires.
//   CLOCK_50            : clock
//   reset               : asynchronous, active-high
//   dispenseMorning/Afternoon/Evening : one-cycle request pulses
//   pill_sensor         : raw asynchronous drop sensor, high = pill in chute
//   patient_ack         : debounced acknowledgement level
//   motor_en            : carousel motor drive
//   compartment         : 0 none, 1 morning, 2 afternoon, 3 evening
//   busy, alarm, fault  : status levels
//   dose_taken, dose_missed : one-cycle event pulses
module dispense_actuator
  import dispense_actuator_pkg::*;
#(
  parameter int CLKS_PER_MS     = 50000,
  parameter int ROTATE_MS       = 500,
  parameter int DROP_TIMEOUT_MS = 2000,
  parameter int MAX_RETRY       = 2,
  parameter int ACK_TIMEOUT_MS  = 60000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       dispenseMorning,
  input  logic       dispenseAfternoon,
  input  logic       dispenseEvening,
  input  logic       pill_sensor,
  input  logic       patient_ack,
  output logic       motor_en,
  output logic [1:0] compartment,
  output logic       busy,
  output logic       alarm,
  output logic       fault,
  output logic       dose_taken,
  output logic       dose_missed
);

  localparam int RD_MAX    = (ROTATE_MS > DROP_TIMEOUT_MS) ? ROTATE_MS : DROP_TIMEOUT_MS;
  localparam int TIMER_MAX = (RD_MAX > ACK_TIMEOUT_MS) ? RD_MAX : ACK_TIMEOUT_MS;
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int AW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Timers compare against limit-1 so the transition happens on the tick
  // that completes the window.
  localparam logic [TW-1:0] ROTATE_LAST = TW'(ROTATE_MS - 1);
  localparam logic [TW-1:0] DROP_LAST   = TW'(DROP_TIMEOUT_MS - 1);
  localparam logic [TW-1:0] ACK_LAST    = TW'(ACK_TIMEOUT_MS - 1);
  localparam logic [AW-1:0] RETRY_LIMIT = AW'(MAX_RETRY);

  logic          tick;
  logic          sync_meta, sync_pill, sync_prev, drop_edge;
  state_t        state, state_next;
  logic [2:0]    pending, req, clear_mask;
  comp_t         sel, pick;
  logic [AW-1:0] attempt;
  logic [TW-1:0] timer;
  logic          timed, load_sel, retry, taken_next, missed_next;

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_ms_tick_gen (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .tick    (tick)
  );

  // Sensor synchroniser (meta -> pill) plus one flop for rising-edge detect
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_pill <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= pill_sensor;
      sync_pill <= sync_meta;
      sync_prev <= sync_pill;
    end
  end

  assign drop_edge = sync_pill & ~sync_prev;
  assign req       = {dispenseEvening, dispenseAfternoon, dispenseMorning};
  assign pick      = pick_compartment(pending);
  assign timed     = (state == ST_ROTATE) || (state == ST_WAIT_DROP) || (state == ST_ALERT);

  // Next-state logic; drop and ack take priority over a coincident timeout
  always_comb begin
    state_next  = state;
    clear_mask  = 3'b000;
    load_sel    = 1'b0;
    retry       = 1'b0;
    taken_next  = 1'b0;
    missed_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pending) begin
          state_next = ST_ROTATE;
          clear_mask = comp_mask(pick);
          load_sel   = 1'b1;
        end
      end
      ST_ROTATE: begin
        if (tick && (timer == ROTATE_LAST)) state_next = ST_WAIT_DROP;
      end
      ST_WAIT_DROP: begin
        if (drop_edge) begin
          state_next = ST_ALERT;
        end else if (tick && (timer == DROP_LAST)) begin
          if (attempt < RETRY_LIMIT) begin
            state_next = ST_ROTATE;
            retry      = 1'b1;
          end else begin
            state_next = ST_FAULT;
          end
        end
      end
      ST_ALERT: begin
        if (patient_ack) begin
          state_next = ST_IDLE;
          taken_next = 1'b1;
        end else if (tick && (timer == ACK_LAST)) begin
          state_next  = ST_IDLE;
          missed_next = 1'b1;
        end
      end
      ST_FAULT: begin
        if (patient_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= 3'b000;
      sel         <= COMP_NONE;
      attempt     <= '0;
      timer       <= '0;
      dose_taken  <= 1'b0;
      dose_missed <= 1'b0;
    end else begin
      state       <= state_next;
      // A request arriving on the dequeue cycle re-sets its bit
      pending     <= (pending & ~clear_mask) | req;
      dose_taken  <= taken_next;
      dose_missed <= missed_next;
      if (load_sel) begin
        sel     <= pick;
        attempt <= '0;
      end else if (retry) begin
        attempt <= attempt + 1'b1;
      end
      if (state_next != state) begin
        timer <= '0;
      end else if (tick && timed) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Outputs decode the state register directly so reset clears them at once
  assign motor_en    = (state == ST_ROTATE);
  assign busy        = (state != ST_IDLE);
  assign alarm       = (state == ST_ALERT) || (state == ST_FAULT);
  assign fault       = (state == ST_FAULT);
  assign compartment = (state == ST_IDLE) ? COMP_NONE : sel;

endmodule
